// File: rtl/rv32im_fetch_pkg.sv
// Shared constants and types for the rv32im instruction-fetch stage.
package rv32im_fetch_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          FETCH_ENTRY_W = 64;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push/pop/flush and an occupancy count.
// Flush wins over a push in the same cycle; overflow is prevented upstream.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every register samples pre-edge values.
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is left unreset; the count alone decides what is valid.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: in-order requests to a variable-latency imem,
// prefetch buffering, decode register with stall, redirect and ebreak halt.
module if_fetch_unit
  import rv32im_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_D,
  input  logic        PCnew_D,
  input  logic [31:0] PCin1_D,
  input  logic        ebreak_D,
  output logic [31:0] PC_D,
  output logic [31:0] instruction_D,
  output logic        valid_D,
  output logic        halted
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      rsp_pc;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] outstanding_next;
  logic [OUT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  fetch_entry_t     push_entry;
  fetch_entry_t     pop_entry;
  logic             req_fire;
  logic             rsp_fire;
  logic             rsp_drop;
  logic             rsp_push;
  logic             halt_go;
  logic             flush_all;
  logic             fifo_pop;
  logic             budget_ok;

  // Buffered entries plus live (non-dropped) requests must fit in the FIFO.
  assign budget_ok = (int'(fifo_count) + int'(outstanding) - int'(drop_cnt)) < FIFO_DEPTH;

  assign imem_req_valid = (state == ST_RUN) && !rst && !PCnew_D &&
                          (int'(outstanding) < MAX_OUTSTANDING) && budget_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is ignored rather than corrupting counters.
  assign rsp_fire = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_fire && (drop_cnt != '0);
  assign rsp_push = rsp_fire && (drop_cnt == '0) && !flush_all;

  assign outstanding_next = outstanding + OUT_W'(req_fire) - OUT_W'(rsp_fire);

  assign halt_go   = (state == ST_RUN) && valid_D && !stall_D && !PCnew_D && ebreak_D;
  assign flush_all = PCnew_D || halt_go || (state == ST_HALT);
  assign fifo_pop  = !stall_D && !flush_all && !fifo_empty;
  assign halted    = (state == ST_HALT);

  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .pop       (fifo_pop),
    .flush     (flush_all),
    .push_data (push_entry),
    .pop_data  (pop_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // FSM next state: RUN falls into HALT on an accepted ebreak; only reset leaves HALT.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    if (halt_go) state_next = ST_HALT;
  end

  // Fetch/response PCs and the in-flight / to-be-dropped counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (PCnew_D) begin
        fetch_pc <= align_word(PCin1_D);
        rsp_pc   <= align_word(PCin1_D);
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_push) rsp_pc   <= rsp_pc + 32'd4;
        if (halt_go)       drop_cnt <= outstanding_next;
        else if (rsp_drop) drop_cnt <= drop_cnt - OUT_W'(1);
      end
    end
  end

  // Decode register: redirect/halt bubble, then stall hold, then pop or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC_D          <= '0;
      instruction_D <= NOP_INSTR;
      valid_D       <= 1'b0;
    end else if (flush_all) begin
      instruction_D <= NOP_INSTR;
      valid_D       <= 1'b0;
    end else if (!stall_D) begin
      if (!fifo_empty) begin
        PC_D          <= pop_entry.pc;
        instruction_D <= pop_entry.instr;
        valid_D       <= 1'b1;
      end else begin
        instruction_D <= NOP_INSTR;
        valid_D       <= 1'b0;
      end
    end
  end

  // The memory must never answer when no request is in flight.
  assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with an in-order imem model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        stall_D        = 1'b0;
  logic        PCnew_D        = 1'b0;
  logic [31:0] PCin1_D        = '0;
  logic        ebreak_D;
  logic [31:0] PC_D;
  logic [31:0] instruction_D;
  logic        valid_D;
  logic        halted;

  int total = 0;
  int bad   = 0;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_D        (stall_D),
    .PCnew_D        (PCnew_D),
    .PCin1_D        (PCin1_D),
    .ebreak_D       (ebreak_D),
    .PC_D           (PC_D),
    .instruction_D  (instruction_D),
    .valid_D        (valid_D),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Memory contents: one ebreak at 0x300, otherwise the inverted address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h300) ? EBREAK : ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Decoder stand-in: ebreak recognised only when enabled by the test.
  logic ebreak_en = 1'b0;
  assign ebreak_D = ebreak_en && valid_D && (instruction_D == EBREAK);

  // ---------------- imem model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc       = 0;
  int          lat       = 1;
  bit          rand_mode = 1'b0;
  logic        s_hs      = 1'b0;
  logic        s_rsp     = 1'b0;
  logic        s_rst     = 1'b1;
  logic [31:0] s_addr    = '0;

  always @(negedge clk) begin
    s_hs   = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_rsp  = imem_rsp_valid;
    s_rst  = rst;
  end

  always @(posedge clk) begin
    int l;
    #1;
    cyc++;
    if (s_rst) begin
      mq.delete();
    end else begin
      if (s_rsp && mq.size() > 0) void'(mq.pop_front());
      if (s_hs) begin
        l = rand_mode ? int'($urandom_range(1, 4)) : lat;
        mq.push_back('{addr: s_addr, due: cyc - 1 + l});
      end
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- soak monitor (in-order reference) ----------------
  bit          soak_on  = 1'b0;
  logic [31:0] req_pc   = '0;
  logic [31:0] dec_pc   = '0;
  int          consumed = 0;

  always @(negedge clk) begin
    if (soak_on) begin
      if (imem_req_valid && imem_req_ready) begin
        check("soak_req_addr", imem_req_addr, req_pc);
        req_pc = req_pc + 32'd4;
      end
      if (valid_D && !stall_D) begin
        check("soak_pc", PC_D, dec_pc);
        check("soak_instr", instruction_D, word(dec_pc));
        dec_pc = dec_pc + 32'd4;
        consumed++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for three cycles; returns at the start of the first cycle out of reset.
  task automatic do_reset();
    tick();
    rst     = 1'b1;
    stall_D = 1'b0;
    PCnew_D = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_bit("rst_req_valid", imem_req_valid, 1'b0);
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (valid_D) found = 1'b1;
    end
    if (!found) check_bit({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        stall;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // Zero-wait memory from reset, then a 5-cycle stall in cycles 6..10.
    tbl[0]  = '{1'b0, 1'b0, 32'd0,  1'b1};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,  1'b1};
    tbl[2]  = '{1'b0, 1'b0, 32'd0,  1'b1};
    tbl[3]  = '{1'b0, 1'b1, 32'd0,  1'b1};
    tbl[4]  = '{1'b0, 1'b1, 32'd4,  1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'd8,  1'b1};
    tbl[6]  = '{1'b1, 1'b1, 32'd12, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 32'd12, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 32'd12, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 32'd12, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'd12, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'd12, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'd16, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 32'd20, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'd24, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 32'd28, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 32'd32, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 32'd36, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 32'd40, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 32'd44, 1'b1};

    // Streaming and stall
    lat = 1;
    do_reset();
    @(negedge clk);
    check("reset_pc_d", PC_D, 32'd0);
    check("reset_instr", instruction_D, NOP);
    check_bit("reset_valid", valid_D, 1'b0);
    check_bit("reset_halted", halted, 1'b0);
    check("reset_req_addr", imem_req_addr, 32'd0);
    tick();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      stall_D = tbl[i].stall;
      @(negedge clk);
      check_bit($sformatf("tbl%0d_valid", i), valid_D, tbl[i].exp_valid);
      check($sformatf("tbl%0d_pc", i), PC_D, tbl[i].exp_pc);
      check($sformatf("tbl%0d_instr", i), instruction_D,
            tbl[i].exp_valid ? word(tbl[i].exp_pc) : NOP);
      check_bit($sformatf("tbl%0d_req", i), imem_req_valid, tbl[i].exp_req);
      tick();
    end
    stall_D = 1'b0;

    // Redirect with two stale requests in flight (latency 3)
    lat = 3;
    do_reset();
    @(negedge clk);
    check_bit("t3_req0_valid", imem_req_valid, 1'b1);
    check("t3_req0_addr", imem_req_addr, 32'h0);
    tick();
    @(negedge clk);
    check_bit("t3_req1_valid", imem_req_valid, 1'b1);
    check("t3_req1_addr", imem_req_addr, 32'h4);
    tick();
    PCnew_D = 1'b1;
    PCin1_D = 32'h100;
    @(negedge clk);
    check_bit("t3_redirect_noreq", imem_req_valid, 1'b0);
    tick();
    PCnew_D = 1'b0;
    @(negedge clk);
    check_bit("t3_full_noreq", imem_req_valid, 1'b0);
    check_bit("t3_bubble", valid_D, 1'b0);
    tick();
    @(negedge clk);
    check_bit("t3_target_req", imem_req_valid, 1'b1);
    check("t3_target_addr", imem_req_addr, 32'h100);
    wait_valid("t3_first");
    check("t3_first_pc", PC_D, 32'h100);
    check("t3_first_instr", instruction_D, word(32'h100));
    @(negedge clk);
    check_bit("t3_second_valid", valid_D, 1'b1);
    check("t3_second_pc", PC_D, 32'h104);

    // Redirect together with stall and an arriving response
    lat = 1;
    do_reset();
    repeat (5) tick();
    stall_D = 1'b1;
    PCnew_D = 1'b1;
    PCin1_D = 32'h203;
    @(negedge clk);
    check("t4_pre_pc", PC_D, 32'd8);
    check_bit("t4_rsp_present", imem_rsp_valid, 1'b1);
    check_bit("t4_redirect_noreq", imem_req_valid, 1'b0);
    tick();
    stall_D = 1'b0;
    PCnew_D = 1'b0;
    @(negedge clk);
    check_bit("t4_bubble_valid", valid_D, 1'b0);
    check("t4_bubble_instr", instruction_D, NOP);
    check("t4_bubble_pc_held", PC_D, 32'd8);
    check_bit("t4_target_req", imem_req_valid, 1'b1);
    check("t4_target_addr", imem_req_addr, 32'h200);
    wait_valid("t4_first");
    check("t4_first_pc", PC_D, 32'h200);
    check("t4_first_instr", instruction_D, word(32'h200));

    // ebreak halts fetch until reset
    do_reset();
    ebreak_en = 1'b1;
    PCnew_D   = 1'b1;
    PCin1_D   = 32'h2F8;
    tick();
    PCnew_D = 1'b0;
    begin
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (valid_D && PC_D == 32'h300) found = 1'b1;
      end
      check_bit("t5_reach_ebreak", found, 1'b1);
    end
    check("t5_ebreak_instr", instruction_D, EBREAK);
    check_bit("t5_not_yet_halted", halted, 1'b0);
    @(negedge clk);
    check_bit("t5_halted", halted, 1'b1);
    check_bit("t5_bubble", valid_D, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_bit($sformatf("t5_noreq%0d", i), imem_req_valid, 1'b0);
      check_bit($sformatf("t5_novalid%0d", i), valid_D, 1'b0);
      check_bit($sformatf("t5_stay%0d", i), halted, 1'b1);
    end
    tick();
    ebreak_en = 1'b0;
    do_reset();
    @(negedge clk);
    check_bit("t5_reset_clears_halt", halted, 1'b0);
    check_bit("t5_req_after_reset", imem_req_valid, 1'b1);

    // Address wrap plus random ready/latency/stall soak
    rand_mode = 1'b1;
    do_reset();
    PCnew_D  = 1'b1;
    PCin1_D  = 32'hFFFF_FFF0;
    req_pc   = 32'hFFFF_FFF0;
    dec_pc   = 32'hFFFF_FFF0;
    consumed = 0;
    soak_on  = 1'b1;
    tick();
    PCnew_D = 1'b0;
    for (int i = 0; i < 600; i++) begin
      stall_D = ($urandom_range(0, 3) == 0);
      tick();
    end
    stall_D = 1'b0;
    soak_on = 1'b0;
    check_bit("soak_progress", consumed >= 40, 1'b1);
    check_bit("soak_wrapped", dec_pc < 32'h1000, 1'b1);
    rand_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
